jt12_eg_ctrl: RTL and testbench



---
 rtl/jt12_eg_pkg.sv | 42 ++++
 rtl/jt12_eg_ctrl_if.sv | 41 ++++
 rtl/jt12_eg_cnt.sv | 37 +++
 rtl/jt12_eg_ctrl.sv | 116 +++++++++++
 tb/tb_jt12_eg_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jt12_eg_pkg.sv
`default_nettype none
//==============================================================================
// Module   : jt12_eg_pkg
// Brief    : Shared types, step patterns and effective-rate helper for the EG
// Revision : 1.0 - initial release
//==============================================================================
package jt12_eg_pkg;

   typedef enum logic [1:0] {
      ATTACK  = 2'd0,
      DECAY   = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } eg_phase_e;

   localparam logic [9:0] EG_MAX = 10'h3FF;

   // Row = R[1:0], bit = position within the 8-step sub-cycle
   localparam logic [7:0] c_step_pat [4] = '{
      8'b10101010,
      8'b11101010,
      8'b11101110,
      8'b11111110
   };

   function automatic logic [5:0] eff_rate(
      input logic [4:0] r,
      input logic [4:0] kc,
      input logic [1:0] ks
   );
      logic [6:0] w_sum;
      w_sum = {1'b0, r, 1'b0} + {2'b00, kc >> (2'd3 - ks)};
      if (r == 5'd0)
         eff_rate = 6'd0;
      else if (w_sum > 7'd63)
         eff_rate = 6'h3F;
      else
         eff_rate = w_sum[5:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_eg_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : jt12_eg_ctrl_if
// Brief    : Register-file / attenuation-stage bundle around the EG controller
// Revision : 1.0 - initial release
//==============================================================================
interface jt12_eg_ctrl_if;
   import jt12_eg_pkg::*;

   logic       clk_en;
   logic       keyon;
   logic [4:0] ar;
   logic [4:0] d1r;
   logic [4:0] d2r;
   logic [3:0] rr;
   logic [3:0] sl;
   logic [1:0] ks;
   logic [4:0] kc;
   logic       ssg_en_in;
   logic [9:0] eg_next;

   logic       attack;
   logic       step;
   logic [4:0] rate;
   logic       ssg_en;
   logic       sum_up;
   logic [9:0] eg_in;
   logic [1:0] phase;

   modport master (
      output clk_en, keyon, ar, d1r, d2r, rr, sl, ks, kc, ssg_en_in, eg_next,
      input  attack, step, rate, ssg_en, sum_up, eg_in, phase
   );

   modport slave (
      input  clk_en, keyon, ar, d1r, d2r, rr, sl, ks, kc, ssg_en_in, eg_next,
      output attack, step, rate, ssg_en, sum_up, eg_in, phase
   );

endinterface
`default_nettype wire

// File: rtl/jt12_eg_cnt.sv
`default_nettype none
//==============================================================================
// Module   : jt12_eg_cnt
// Brief    : Divide-by-3 envelope tick and global envelope counter
// Revision : 1.0 - initial release
//==============================================================================
module jt12_eg_cnt
   import jt12_eg_pkg::*;
#(
   parameter int CNT_W = 12
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_clk_en,
   output logic                  o_eg_tick,
   output logic [CNT_W-1:0]      o_cnt
);

   logic [1:0]       r_div;
   logic [CNT_W-1:0] r_cnt;

   assign o_eg_tick = i_clk_en & (r_div == 2'd2);
   assign o_cnt     = r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= 2'd0;
         r_cnt <= '0;
      end else if (i_clk_en) begin
         r_div <= (r_div == 2'd2) ? 2'd0 : r_div + 2'd1;
         if (r_div == 2'd2)
            r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/jt12_eg_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : jt12_eg_ctrl
// Brief    : Single-operator ADSR controller; JT12_EG_SSG_EN enables SSG repeat
// Revision : 1.0 - initial release
//==============================================================================
module jt12_eg_ctrl
   import jt12_eg_pkg::*;
#(
   parameter int CNT_W = 12
) (
   input  wire logic      clk,
   input  wire logic      rst,
   jt12_eg_ctrl_if.slave  bus
);

   localparam logic [1:0] c_st_attack  = ATTACK;
   localparam logic [1:0] c_st_decay   = DECAY;
   localparam logic [1:0] c_st_sustain = SUSTAIN;
   localparam logic [1:0] c_st_release = RELEASE;

   logic             w_eg_tick;
   logic [CNT_W-1:0] w_cnt;

   logic [1:0]       r_state;
   logic [9:0]       r_eg_q;
   logic             r_keyon_q;

   logic [4:0]       w_base;
   logic [5:0]       w_rate6;
   logic [3:0]       w_h;
   logic [3:0]       w_shift;
   logic [CNT_W-1:0] w_mask;
   logic [2:0]       w_idx;
   logic             w_rise;
   logic             w_fall;
   logic             w_retrig;
   logic [9:0]       w_sl_thr;
   logic [1:0]       w_state_nx;

   jt12_eg_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_clk_en  (bus.clk_en),
      .o_eg_tick (w_eg_tick),
      .o_cnt     (w_cnt)
   );

   always_comb begin
      w_base = bus.ar;
      case (r_state)
         c_st_decay:   w_base = bus.d1r;
         c_st_sustain: w_base = bus.d2r;
         c_st_release: w_base = {bus.rr, 1'b1};
         default:      w_base = bus.ar;
      endcase
   end

   assign w_rate6 = eff_rate(w_base, bus.kc, bus.ks);
   assign w_h     = w_rate6[5:2];
   assign w_shift = (w_h <= 4'd11) ? (4'd11 - w_h) : 4'd0;
   // A zero shift yields an all-zero mask, so the empty-slice case is true
   assign w_mask  = ~({CNT_W{1'b1}} << w_shift);
   assign w_idx   = 3'({3'b000, w_cnt} >> w_shift);

   assign bus.sum_up = w_eg_tick & (w_rate6 != 6'd0) & ((w_cnt & w_mask) == '0);
   assign bus.step   = c_step_pat[w_rate6[1:0]][w_idx];
   assign bus.rate   = w_rate6[5:1];
   assign bus.attack = (r_state == c_st_attack);
   assign bus.phase  = r_state;
   assign bus.eg_in  = r_eg_q;

   assign w_rise   = bus.keyon & ~r_keyon_q;
   assign w_fall   = ~bus.keyon & r_keyon_q;
   assign w_sl_thr = {(bus.sl == 4'hF) ? 5'h1F : {1'b0, bus.sl}, 5'b00000};

`ifdef JT12_EG_SSG_EN
   assign bus.ssg_en = bus.ssg_en_in;
   assign w_retrig   = bus.ssg_en_in & bus.eg_next[9] &
                       ((r_state == c_st_decay) | (r_state == c_st_sustain));
`else
   logic w_unused_ssg;
   assign bus.ssg_en   = 1'b0;
   assign w_retrig     = 1'b0;
   assign w_unused_ssg = bus.ssg_en_in;
`endif

   // Key edges outrank level-driven transitions
   always_comb begin
      w_state_nx = r_state;
      if (w_rise)
         w_state_nx = c_st_attack;
      else if (w_fall)
         w_state_nx = c_st_release;
      else if (w_retrig)
         w_state_nx = c_st_attack;
      else if ((r_state == c_st_attack) && (bus.eg_next == 10'd0))
         w_state_nx = c_st_decay;
      else if ((r_state == c_st_decay) && (bus.eg_next >= w_sl_thr))
         w_state_nx = c_st_sustain;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= c_st_release;
         r_eg_q    <= EG_MAX;
         r_keyon_q <= 1'b0;
      end else if (bus.clk_en) begin
         r_state   <= w_state_nx;
         r_eg_q    <= bus.eg_next;
         r_keyon_q <= bus.keyon;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jt12_eg_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_jt12_eg_ctrl
// Brief    : Self-checking bench for jt12_eg_ctrl against a behavioural model
// Revision : 1.0 - initial release
//==============================================================================
module tb_jt12_eg_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   jt12_eg_ctrl_if bus ();

   jt12_eg_ctrl #(.CNT_W(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase number, counts of clk_en pulses and envelope ticks
   int m_phase, m_level, m_en, m_ticks, m_kprev;
   int pats [4] = '{'hAA, 'hEA, 'hEE, 'hFE};

   function automatic int model_r();
      int b, k, s;
      case (m_phase)
         0:       b = bus.ar;
         1:       b = bus.d1r;
         2:       b = bus.d2r;
         default: b = bus.rr * 2 + 1;
      endcase
      if (b == 0) return 0;
      k = bus.kc / (1 << (3 - bus.ks));
      s = 2 * b + k;
      return (s > 63) ? 63 : s;
   endfunction

   function automatic int model_shift(int r);
      return (r / 4 <= 11) ? 11 - r / 4 : 0;
   endfunction

   function automatic int model_sum_up();
      int r, sh, cnt;
      r = model_r(); sh = model_shift(r); cnt = m_ticks % 4096;
      return (bus.clk_en && (m_en % 3 == 2) && r != 0 && (cnt % (1 << sh) == 0)) ? 1 : 0;
   endfunction

   function automatic int model_step();
      int r, sh, cnt;
      r = model_r(); sh = model_shift(r); cnt = m_ticks % 4096;
      return (pats[r % 4] >> ((cnt / (1 << sh)) % 8)) & 1;
   endfunction

   task automatic step_clk();
      int  thr;
      bit  rise, fall;
      @(posedge clk);
      if (rst) begin
         m_phase = 3; m_level = 'h3FF; m_en = 0; m_ticks = 0; m_kprev = 0;
      end else if (bus.clk_en) begin
         rise = bus.keyon && !m_kprev;
         fall = !bus.keyon && m_kprev;
         thr  = ((bus.sl == 15) ? 31 : int'(bus.sl)) * 32;
         if (rise) m_phase = 0;
         else if (fall) m_phase = 3;
`ifdef JT12_EG_SSG_EN
         else if ((m_phase == 1 || m_phase == 2) && bus.ssg_en_in && bus.eg_next >= 512) m_phase = 0;
`endif
         else if (m_phase == 0 && bus.eg_next == 0) m_phase = 1;
         else if (m_phase == 1 && int'(bus.eg_next) >= thr) m_phase = 2;
         if (m_en % 3 == 2) m_ticks++;
         m_en++;
         m_level = bus.eg_next;
         m_kprev = bus.keyon;
      end
      #1;
   endtask

   task automatic test_reset();
      int first;
      bus.clk_en = 1; bus.keyon = 0; bus.ar = 31; bus.d1r = 3; bus.d2r = 2;
      bus.rr = 5; bus.sl = 0; bus.ks = 0; bus.kc = 0; bus.ssg_en_in = 0;
      bus.eg_next = 10'h3FF;
      rst = 1; step_clk(); step_clk();
      rst = 0; #1;
      n_cmp++; if (bus.eg_in !== 10'h3FF) begin n_bad++; $display("FAIL reset_eg_in got %h want 3ff", bus.eg_in); end
      n_cmp++; if (bus.phase !== 2'd3) begin n_bad++; $display("FAIL reset_phase got %0d want 3", bus.phase); end
      n_cmp++; if (bus.attack !== 1'b0) begin n_bad++; $display("FAIL reset_attack got %b want 0", bus.attack); end
      n_cmp++; if (bus.step !== 1'b0) begin n_bad++; $display("FAIL reset_step got %b want 0", bus.step); end
      n_cmp++; if (bus.rate !== 5'd11) begin n_bad++; $display("FAIL reset_rate got %0d want 11", bus.rate); end
      first = -1;
      for (int i = 0; i < 6; i++) begin
         if (bus.sum_up === 1'b1 && first < 0) first = i;
         step_clk(); #1;
      end
      n_cmp++; if (first !== 2) begin n_bad++; $display("FAIL reset_first_sum_up got clk_en %0d want 2", first); end
   endtask

   task automatic test_attack_decay();
      bus.ar = 31; bus.ks = 0; bus.kc = 0; bus.eg_next = 0; bus.keyon = 1;
      step_clk(); #1;
      n_cmp++; if (bus.attack !== 1'b1 || bus.phase !== 2'd0) begin n_bad++; $display("FAIL ad_attack got attack=%b phase=%0d want 1/0", bus.attack, bus.phase); end
      n_cmp++; if (bus.eg_in !== 10'd0) begin n_bad++; $display("FAIL ad_eg_in got %h want 000", bus.eg_in); end
      step_clk(); #1;
      n_cmp++; if (bus.attack !== 1'b0 || bus.phase !== 2'd1) begin n_bad++; $display("FAIL ad_decay got attack=%b phase=%0d want 0/1", bus.attack, bus.phase); end
   endtask

   task automatic test_decay_sustain();
      bus.sl = 4; bus.eg_next = 10'h07F;
      step_clk(); #1;
      n_cmp++; if (bus.phase !== 2'd1) begin n_bad++; $display("FAIL ds_below got %0d want 1", bus.phase); end
      bus.eg_next = 10'h080;
      step_clk(); #1;
      n_cmp++; if (bus.phase !== 2'd2) begin n_bad++; $display("FAIL ds_at_thr got %0d want 2", bus.phase); end
      bus.keyon = 0; step_clk();
      bus.keyon = 1; bus.eg_next = 0; step_clk(); step_clk();
      bus.sl = 15; bus.eg_next = 10'h3DF;
      step_clk(); #1;
      n_cmp++; if (bus.phase !== 2'd1) begin n_bad++; $display("FAIL ds_sl15_below got %0d want 1", bus.phase); end
      bus.eg_next = 10'h3E0;
      step_clk(); #1;
      n_cmp++; if (bus.phase !== 2'd2) begin n_bad++; $display("FAIL ds_sl15_thr got %0d want 2", bus.phase); end
   endtask

   task automatic test_rate_step();
      bus.keyon = 0; step_clk();
      bus.keyon = 1; bus.eg_next = 0; step_clk(); step_clk();
      bus.sl = 15; bus.eg_next = 10'h010;
      bus.d1r = 5; bus.kc = 0; bus.ks = 0; #1;
      n_cmp++; if (bus.rate !== 5'd5) begin n_bad++; $display("FAIL rate_r10 got %0d want 5", bus.rate); end
      for (int i = 0; i < 1700; i++) begin
         n_cmp++; if (bus.sum_up !== 1'(model_sum_up()) || bus.step !== 1'(model_step())) begin
            n_bad++; $display("FAIL r10_seq i=%0d got su=%b st=%b want su=%0d st=%0d", i, bus.sum_up, bus.step, model_sum_up(), model_step());
         end
         step_clk(); #1;
      end
      bus.d1r = 31; bus.kc = 31; bus.ks = 3; #1;
      n_cmp++; if (bus.rate !== 5'd31) begin n_bad++; $display("FAIL rate_sat got %0d want 31", bus.rate); end
      bus.d1r = 0; #1;
      n_cmp++; if (bus.rate !== 5'd0) begin n_bad++; $display("FAIL rate_zero got %0d want 0", bus.rate); end
      for (int i = 0; i < 6; i++) begin
         n_cmp++; if (bus.sum_up !== 1'b0) begin n_bad++; $display("FAIL rate_zero_sum_up i=%0d got %b want 0", i, bus.sum_up); end
         step_clk(); #1;
      end
   endtask

   task automatic test_simultaneous();
      bus.d1r = 7; bus.keyon = 0; step_clk();
      bus.keyon = 1; bus.eg_next = 5; step_clk();
      bus.keyon = 0; bus.eg_next = 0; step_clk(); #1;
      n_cmp++; if (bus.phase !== 2'd3) begin n_bad++; $display("FAIL sim_off_vs_zero got %0d want 3", bus.phase); end
      bus.keyon = 1; step_clk(); #1;
      n_cmp++; if (bus.phase !== 2'd0) begin n_bad++; $display("FAIL sim_reon got %0d want 0", bus.phase); end
   endtask

   task automatic test_ssg();
      int exp_ph, exp_en;
`ifdef JT12_EG_SSG_EN
      exp_ph = 0; exp_en = 1;
`else
      exp_ph = 2; exp_en = 0;
`endif
      bus.ssg_en_in = 0; bus.eg_next = 0; step_clk();
      bus.sl = 2; bus.eg_next = 10'h100; step_clk(); #1;
      n_cmp++; if (bus.phase !== 2'd2) begin n_bad++; $display("FAIL ssg_setup got %0d want 2", bus.phase); end
      bus.ssg_en_in = 1; bus.eg_next = 10'h200; #1;
      n_cmp++; if (bus.ssg_en !== 1'(exp_en)) begin n_bad++; $display("FAIL ssg_en got %b want %0d", bus.ssg_en, exp_en); end
      step_clk(); #1;
      n_cmp++; if (bus.phase !== 2'(exp_ph)) begin n_bad++; $display("FAIL ssg_retrig got %0d want %0d", bus.phase, exp_ph); end
      bus.ssg_en_in = 0;
   endtask

   task automatic test_clk_en_hold();
      logic [1:0] ph;
      logic [9:0] lv;
      ph = bus.phase; lv = bus.eg_in;
      bus.clk_en = 0;
      for (int i = 0; i < 5; i++) begin
         bus.keyon = ~bus.keyon; bus.eg_next = 10'($urandom); bus.d2r = 31; bus.ar = 31;
         step_clk(); #1;
         n_cmp++; if (bus.phase !== ph || bus.eg_in !== lv || bus.sum_up !== 1'b0) begin
            n_bad++; $display("FAIL hold i=%0d got ph=%0d lv=%h su=%b want ph=%0d lv=%h su=0", i, bus.phase, bus.eg_in, bus.sum_up, ph, lv);
         end
      end
      bus.clk_en = 1; bus.keyon = 0; step_clk();
   endtask

   task automatic test_reset_midnote();
      bus.keyon = 1; step_clk();
      rst = 1; step_clk(); #1;
      n_cmp++; if (bus.phase !== 2'd3 || bus.eg_in !== 10'h3FF) begin n_bad++; $display("FAIL midnote_reset got ph=%0d lv=%h want 3/3ff", bus.phase, bus.eg_in); end
      rst = 0; step_clk(); #1;
      n_cmp++; if (bus.phase !== 2'd0) begin n_bad++; $display("FAIL midnote_rise got %0d want 0", bus.phase); end
   endtask

   task automatic test_random();
      int exp_ssg;
      for (int i = 0; i < 2500; i++) begin
         bus.clk_en = ($urandom_range(7) != 0);
         if ($urandom_range(15) == 0) bus.keyon = ~bus.keyon;
         bus.ar = 5'($urandom); bus.d1r = 5'($urandom); bus.d2r = 5'($urandom);
         bus.rr = 4'($urandom); bus.sl = 4'($urandom); bus.ks = 2'($urandom);
         bus.kc = 5'($urandom); bus.ssg_en_in = 1'($urandom);
         if ($urandom_range(3) == 0) bus.eg_next = 0; else bus.eg_next = 10'($urandom);
`ifdef JT12_EG_SSG_EN
         exp_ssg = bus.ssg_en_in;
`else
         exp_ssg = 0;
`endif
         #1;
         n_cmp++; if (bus.phase !== 2'(m_phase) || bus.attack !== (m_phase == 0)) begin
            n_bad++; $display("FAIL rnd_phase i=%0d got %0d/%b want %0d", i, bus.phase, bus.attack, m_phase);
         end
         n_cmp++; if (bus.eg_in !== 10'(m_level)) begin n_bad++; $display("FAIL rnd_eg_in i=%0d got %h want %h", i, bus.eg_in, m_level); end
         n_cmp++; if (bus.rate !== 5'(model_r() / 2)) begin n_bad++; $display("FAIL rnd_rate i=%0d got %0d want %0d", i, bus.rate, model_r() / 2); end
         n_cmp++; if (bus.sum_up !== 1'(model_sum_up())) begin n_bad++; $display("FAIL rnd_sum_up i=%0d got %b want %0d", i, bus.sum_up, model_sum_up()); end
         n_cmp++; if (bus.step !== 1'(model_step())) begin n_bad++; $display("FAIL rnd_step i=%0d got %b want %0d", i, bus.step, model_step()); end
         n_cmp++; if (bus.ssg_en !== 1'(exp_ssg)) begin n_bad++; $display("FAIL rnd_ssg_en i=%0d got %b want %0d", i, bus.ssg_en, exp_ssg); end
         step_clk();
      end
   endtask

   initial begin
      bus.clk_en = 0; bus.keyon = 0; bus.ar = 0; bus.d1r = 0; bus.d2r = 0;
      bus.rr = 0; bus.sl = 0; bus.ks = 0; bus.kc = 0; bus.ssg_en_in = 0;
      bus.eg_next = 10'h3FF;
      m_phase = 3; m_level = 'h3FF; m_en = 0; m_ticks = 0; m_kprev = 0;
      test_reset();
      test_attack_decay();
      test_decay_sustain();
      test_rate_step();
      test_simultaneous();
      test_ssg();
      test_clk_en_hold();
      test_reset_midnote();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
